// File: rtl/cordic_ln_seq_fx.sv
// Sequential hyperbolic-vectoring CORDIC natural logarithm, ln(T) = 2*atanh((m-1)/(m+1)) + k*ln2,
// with leading-one range normalisation and a BEG/READY/ACK handshake.
module cordic_ln_seq_fx #(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int ITER = 16,
    parameter int G    = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         BEG,
    input  logic         ACK,
    input  logic [W-1:0] T,
    output logic         READY,
    output logic         BUSY,
    output logic         ERR,
    output logic [W-1:0] RESULT,
    output logic [4:0]   CONT_ITERA
);

    localparam int WI = W + G + 2;
    localparam int FG = FRAC + G;
    localparam int PW = $clog2(W);
    localparam int KW = PW + 1;
    localparam int RW = WI + KW + 2;

    localparam logic [63:0]          LN2_Q64 = 64'hB17217F7D1CF79AB;
    localparam logic signed [RW-1:0] LN2_C   = RW'(LN2_Q64 >> (64 - FG));
    localparam logic signed [WI-1:0] ONE     = {{(WI-FG-1){1'b0}}, 1'b1, {FG{1'b0}}};
    localparam logic signed [RW-1:0] HALF    = RW'(1) << (G - 1);
    localparam logic signed [RW-1:0] SMAX    = (RW'(1) << (W - 1)) - RW'(1);
    localparam logic signed [RW-1:0] SMIN    = ~SMAX;

    typedef enum logic [2:0] {S_IDLE, S_NORM, S_ITER, S_FIN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [W-1:0]          r_t;
    logic signed [WI-1:0]  r_x;
    logic signed [WI-1:0]  r_y;
    logic signed [WI-1:0]  r_z;
    logic signed [KW-1:0]  r_k;
    logic [4:0]            r_i;
    logic                  r_rep;
    logic                  r_err;
    logic [W-1:0]          r_result;

    logic [PW-1:0]         w_p;
    logic [PW-1:0]         w_shamt;
    logic [W-1:0]          w_norm;
    logic [W-1:0]          w_mfrac;
    logic signed [WI-1:0]  w_m;
    logic signed [KW-1:0]  w_k;
    logic signed [WI-1:0]  w_xs;
    logic signed [WI-1:0]  w_ys;
    logic signed [WI-1:0]  w_ang;
    logic                  w_neg;
    logic                  w_hold;
    logic                  w_last;
    logic signed [RW-1:0]  w_zx;
    logic signed [RW-1:0]  w_kx;
    logic signed [RW-1:0]  w_r;
    logic signed [RW-1:0]  w_rr;
    logic [W-1:0]          w_sat;

    // atanh(2^-i) at 32 fractional bits; beyond i=10 the cubic term is below one LSB.
    function automatic logic [31:0] atanh_q32(input logic [4:0] i);
        case (i)
            5'd1:    atanh_q32 = 32'd2359251925;
            5'd2:    atanh_q32 = 32'd1096989674;
            5'd3:    atanh_q32 = 32'd539693625;
            5'd4:    atanh_q32 = 32'd268785802;
            5'd5:    atanh_q32 = 32'd134261444;
            5'd6:    atanh_q32 = 32'd67114326;
            5'd7:    atanh_q32 = 32'd33555114;
            5'd8:    atanh_q32 = 32'd16777301;
            5'd9:    atanh_q32 = 32'd8388618;
            5'd10:   atanh_q32 = 32'd4194305;
            default: atanh_q32 = 32'h1 << (32 - int'(i));
        endcase
    endfunction

    always_comb begin
        w_p = '0;
        for (int b = 0; b < W; b++) begin
            if (r_t[b]) w_p = PW'(b);
        end
    end

    // Leading one lands on the MSB, read as weight 2^-1, so m is in [0.5,1).
    assign w_shamt = PW'(W - 1) - w_p;
    assign w_norm  = r_t << w_shamt;
    assign w_mfrac = w_norm >> (W - FG);
    assign w_m     = $signed({{(WI-W){1'b0}}, w_mfrac});
    assign w_k     = $signed({1'b0, w_p}) - KW'(FRAC - 1);

    assign w_xs   = r_x >>> r_i;
    assign w_ys   = r_y >>> r_i;
    assign w_ang  = WI'({atanh_q32(r_i), 32'h0} >> (64 - FG));
    assign w_neg  = r_y[WI-1];
    assign w_hold = ((r_i == 5'd4) || (r_i == 5'd13)) && !r_rep;
    assign w_last = (r_i == 5'(ITER)) && !w_hold;

    assign w_zx = {{(RW-WI){r_z[WI-1]}}, r_z};
    assign w_kx = {{(RW-KW){r_k[KW-1]}}, r_k};
    assign w_r  = (w_zx <<< 1) + w_kx * LN2_C;
    assign w_rr = (w_r + HALF) >>> G;

    always_comb begin
        if (w_rr > SMAX)      w_sat = SMAX[W-1:0];
        else if (w_rr < SMIN) w_sat = SMIN[W-1:0];
        else                  w_sat = w_rr[W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (BEG) w_state_next = S_NORM;
            S_NORM:  w_state_next = (r_t == '0) ? S_DONE : S_ITER;
            S_ITER:  if (w_last) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_DONE;
            S_DONE:  if (ACK) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_t      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_k      <= '0;
            r_i      <= '0;
            r_rep    <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (BEG) r_t <= T;
                S_NORM: begin
                    if (r_t == '0) begin
                        r_err    <= 1'b1;
                        r_result <= '0;
                    end else begin
                        r_x   <= ONE + w_m;
                        r_y   <= w_m - ONE;
                        r_z   <= '0;
                        r_k   <= w_k;
                        r_i   <= 5'd1;
                        r_rep <= 1'b0;
                    end
                end
                S_ITER: begin
                    // Drive y toward zero; z accumulates atanh(y0/x0) = 0.5*ln(m).
                    if (w_neg) begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_ang;
                    end else begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_ang;
                    end
                    r_rep <= w_hold;
                    if (!w_hold && !w_last) r_i <= r_i + 5'd1;
                end
                S_FIN: begin
                    r_result <= w_sat;
                    r_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign READY      = (r_state == S_DONE);
    assign BUSY       = (r_state == S_NORM) || (r_state == S_ITER) || (r_state == S_FIN);
    assign ERR        = r_err;
    assign RESULT     = r_result;
    assign CONT_ITERA = (r_state == S_ITER) ? r_i : 5'd0;

endmodule

// File: tb/tb_cordic_ln_seq_fx.sv
// Self-checking bench for cordic_ln_seq_fx: vector table, random operands against a real-valued ln model,
// iteration-index trace, handshake, mid-operation reset and a high-precision instance.
module tb_cordic_ln_seq_fx;

    logic        clk = 1'b0;
    logic        rst, beg, ack, beg2, ack2;
    logic [31:0] t, t2;
    logic        ready, busy, err, ready2, busy2, err2;
    logic [31:0] result, result2;
    logic [4:0]  cont, cont2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cordic_ln_seq_fx #(.W(32), .FRAC(16), .ITER(16), .G(3)) u_dut (
        .CLK(clk), .RST(rst), .BEG(beg), .ACK(ack), .T(t),
        .READY(ready), .BUSY(busy), .ERR(err), .RESULT(result), .CONT_ITERA(cont)
    );

    cordic_ln_seq_fx #(.W(32), .FRAC(24), .ITER(24), .G(3)) u_dut24 (
        .CLK(clk), .RST(rst), .BEG(beg2), .ACK(ack2), .T(t2),
        .READY(ready2), .BUSY(busy2), .ERR(err2), .RESULT(result2), .CONT_ITERA(cont2)
    );

    typedef struct {
        logic [31:0] t;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    function automatic int nstep(input int it);
        return it + ((it >= 4) ? 1 : 0) + ((it >= 13) ? 1 : 0);
    endfunction

    function automatic longint ref_ln(input logic [31:0] x, input int frac);
        real v;
        v = $ln(real'(x) / (2.0 ** frac)) * (2.0 ** frac);
        if (v >= 0.0) return longint'($rtoi(v + 0.5));
        else          return -longint'($rtoi(-v + 0.5));
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
        n_cmp++;
        if ((act - exp > tol) || (exp - act > tol)) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h) tol %0d", nm, act, act[31:0], exp, exp[31:0], tol);
        end
    endtask

    task automatic run_op(input logic [31:0] tv, output logic [31:0] res, output logic er, output int lat);
        @(negedge clk);
        t   = tv;
        beg = 1'b1;
        @(negedge clk);
        beg = 1'b0;
        lat = 0;
        while (!ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout T=%h: READY not seen after %0d cycles", tv, lat);
        end
        res = result;
        er  = err;
        $display("op T=%h result=%h err=%0d latency=%0d", tv, res, er, lat);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ready_drop_after_ack", longint'(ready), 0, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"},  longint'(ready),  0, 0);
        chk({tag, "_busy"},   longint'(busy),   0, 0);
        chk({tag, "_err"},    longint'(err),    0, 0);
        chk({tag, "_result"}, longint'(result), 0, 0);
        chk({tag, "_cont"},   longint'(cont),   0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic        er;
        int          lat;
        int          got[$];
        int          want[$];
        logic [31:0] r0;

        rst = 1'b1; beg = 1'b0; ack = 1'b0; t = '0;
        beg2 = 1'b0; ack2 = 1'b0; t2 = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        vecs[0] = '{32'h00000000, 32'h00000000, 1'b1};
        vecs[1] = '{32'h00010000, 32'h00000000, 1'b0};
        vecs[2] = '{32'h0002B7E1, 32'h00010000, 1'b0};
        vecs[3] = '{32'h00100000, 32'h0002C5C8, 1'b0};
        vecs[4] = '{32'h00008000, 32'hFFFF4E8E, 1'b0};
        vecs[5] = '{32'h00000001, 32'hFFF4E8DF, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'h000B1721, 1'b0};

        foreach (vecs[i]) begin
            run_op(vecs[i].t, res, er, lat);
            chk("vec_latency", lat, vecs[i].err ? 1 : nstep(16) + 2, 0);
            chk("vec_err", longint'(er), longint'(vecs[i].err), 0);
            chk("vec_result", longint'($signed(res)), longint'($signed(vecs[i].exp)), vecs[i].err ? 0 : 8);
        end

        // Shift-index trace: NORM shows 0, then i with 4 and 13 repeated, then FIN shows 0.
        want.push_back(0);
        for (int i = 1; i <= 16; i++) begin
            want.push_back(i);
            if (i == 4 || i == 13) want.push_back(i);
        end
        want.push_back(0);
        @(negedge clk);
        t = 32'h00010000;
        beg = 1'b1;
        @(negedge clk);
        beg = 1'b0;
        for (int g = 0; g < 100 && busy; g++) begin
            got.push_back(int'(cont));
            @(negedge clk);
        end
        chk("cont_len", got.size(), want.size(), 0);
        for (int i = 0; i < got.size() && i < want.size(); i++) chk("cont_seq", got[i], want[i], 0);
        chk("trace_ready", longint'(ready), 1, 0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        for (int n = 0; n < 24; n++) begin
            logic [31:0] tv;
            tv = $urandom >> $urandom_range(0, 31);
            if (tv == 0) tv = 32'h1;
            run_op(tv, res, er, lat);
            chk("rand_result", longint'($signed(res)), ref_ln(tv, 16), 8);
            chk("rand_err", longint'(er), 0, 0);
            chk("rand_latency", lat, nstep(16) + 2, 0);
        end

        // BEG held high through the whole operation and DONE.
        @(negedge clk);
        t = 32'h00100000;
        beg = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_latency", lat, nstep(16) + 2, 0);
        r0 = result;
        chk("hold_result", longint'($signed(r0)), ref_ln(32'h00100000, 16), 8);
        repeat (4) begin
            @(negedge clk);
            chk("hold_ready", longint'(ready), 1, 0);
            chk("hold_stable", longint'(result), longint'(r0), 0);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ackbeg_ready", longint'(ready), 0, 0);
        chk("ackbeg_busy", longint'(busy), 0, 0);
        @(negedge clk);
        chk("idle_accept_busy", longint'(busy), 1, 0);
        beg = 1'b0;
        lat = 0;
        while (!ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("second_result", longint'($signed(result)), ref_ln(32'h00100000, 16), 8);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // Reset in the middle of ITER.
        @(negedge clk);
        t = 32'h0002B7E1;
        beg = 1'b1;
        @(negedge clk);
        beg = 1'b0;
        for (int g = 0; g < 100 && cont != 5'd7; g++) @(negedge clk);
        chk("reached_i7", longint'(cont), 7, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midreset");
        rst = 1'b0;
        run_op(32'h00100000, res, er, lat);
        chk("post_reset_result", longint'($signed(res)), 32'h0002C5C8, 8);
        chk("post_reset_latency", lat, nstep(16) + 2, 0);

        // FRAC=24, ITER=24 instance: ln(2.0).
        @(negedge clk);
        t2 = 32'h02000000;
        beg2 = 1'b1;
        @(negedge clk);
        beg2 = 1'b0;
        lat = 0;
        while (!ready2 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        $display("op24 T=%h result=%h err=%0d latency=%0d", t2, result2, err2, lat);
        chk("p24_latency", lat, nstep(24) + 2, 0);
        chk("p24_result", longint'($signed(result2)), 32'h00B17218, 8);
        chk("p24_model", longint'($signed(result2)), ref_ln(32'h02000000, 24), 8);
        chk("p24_err", longint'(err2), 0, 0);
        ack2 = 1'b1;
        @(negedge clk);
        ack2 = 1'b0;
        chk("p24_ready_drop", longint'(ready2), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cordic_ln_seq_fx.md
Name: cordic_ln_seq_fx

Overview:
- Self-sequenced, fixed-point hyperbolic-vectoring CORDIC unit computing RESULT = ln(T) for any positive T in the full input format.
- Generalises the externally controlled floating-point log datapath: internal FSM, parametrised width/precision/iteration count, and leading-one range normalisation (ln T = ln m + k·ln2) instead of a fixed ×16 / ln16 range shift.
- Sits beside the coprocessor as a standalone accelerator with a BEG/READY/ACK handshake.

Parameters:
- W, 32, width of T and RESULT.
- FRAC, 16, fractional bits of T and RESULT (unsigned Q(W-FRAC).FRAC in, signed out). Legal range 8 ≤ FRAC ≤ W-6.
- ITER, 16, number of CORDIC shift indices i = 1..ITER. Legal range 8..30.
- G, 3, guard bits on internal x/y/z datapath (internal width WI = W+G+2).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- BEG  in  1  start request; sampled only in IDLE
- ACK  in  1  result consumed; releases DONE
- T  in  W  unsigned operand, captured on accepted BEG
- READY  out  1  result valid (DONE state)
- BUSY  out  1  high in NORM/ITER/FIN
- ERR  out  1  T==0 on last operation (valid with READY)
- RESULT  out  W  signed ln(T), FRAC fractional bits
- CONT_ITERA  out  5  current shift index i (0 outside ITER)

Behaviour:
- Reset (RST=1 at a CLK edge): state=IDLE; READY=0, BUSY=0, ERR=0, RESULT=0, CONT_ITERA=0; internal x,y,z,k and step counter cleared. Reset wins over every other input, including mid-operation.
- States: IDLE, NORM, ITER, FIN, DONE.
- IDLE: on BEG=1, capture T and go to NORM. BEG is ignored in every other state (no queuing).
- NORM (1 cycle):
  - If T==0: set ERR=1, RESULT=0, go to DONE.
  - Otherwise p = index of leading one of T; m = T aligned so its MSB sits at weight 2^-1 (m in [0.5,1)); k = p-(FRAC-1), signed with clog2(W)+1 bits.
  - Init x = m + 1.0, y = m - 1.0, z = 0, all in WI-bit two's complement with FRAC+G fractional bits.
  - i = 1, go to ITER.
- ITER (one micro-step per cycle):
  - d = +1 if y<0, else -1.
  - x' = x + d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atanh(2^-i). Arithmetic shifts.
  - atanh LUT is 30 entries held at 32 fractional bits, truncated to FRAC+G bits.
  - Indices 4 and 13 (when ≤ ITER) execute twice: first pass holds i, second pass advances.
  - Total steps NSTEP = ITER + (ITER≥4) + (ITER≥13). Default is 18 cycles.
  - After the step with i==ITER (including its repeat if any), go to FIN.
- FIN (1 cycle):
  - r = 2·z + k·LN2, where LN2 is a constant at FRAC+G fractional bits and the product is combinational.
  - Round to nearest, dropping the G guard bits.
  - Saturate to [−2^(W-1), 2^(W-1)−1].
  - Register into RESULT, ERR=0, go to DONE.
- DONE: READY=1, RESULT/ERR held stable. On ACK=1 go to IDLE next cycle (READY=0). BEG=ACK=1 together in DONE: ACK taken, BEG ignored.
- Latency: BEG accepted at edge n → READY=1 after edge n+NSTEP+2. Default is n+20. T==0 gives READY after edge n+1.
- CONT_ITERA shows i during ITER, 0 otherwise. RESULT updates only in FIN/NORM.
- Accuracy (defaults): |RESULT − round(ln T·2^FRAC)| ≤ 8 LSB for all T>0.

Test Plan:
- Defaults, T=0x00010000 (1.0); BEG pulsed → READY exactly 20 cycles after BEG edge, ERR=0, RESULT=0x00000000 ±8 LSB; CONT_ITERA sequence 1,2,3,4,4,5,…,13,13,…,16.
- T=0x0002B7E1 (e) → RESULT=0x00010000 ±8; T=0x00100000 (16) → RESULT=0x0002C5C8 ±8; T=0x00008000 (0.5) → 0xFFFF4E8E ±8.
- Extremes: T=0x00000001 → RESULT=0xFFF4E8DF ±8; T=0xFFFFFFFF → RESULT=0x000B1721 ±8 (≈16·ln2); no saturation.
- T=0 → READY 2 edges after BEG, ERR=1, RESULT=0; next op T=1.0 → ERR cleared, RESULT≈0.
- Handshake: BEG held high through busy and DONE → exactly one operation; RESULT stable until ACK; ACK → READY=0 next cycle, new BEG accepted only from IDLE.
- RST asserted at ITER step 7 → next cycle IDLE, all outputs 0; a subsequent op on T=16 gives a correct result. Repeat with ITER=24, FRAC=24, W=32: T=2.0 → 0x00B17218 ±8.
